adc_sampler: RTL and testbench
==============================

// Module: adc_sampler
// PURPOSE
//   Downstream consumer of the 10-bit serial ADC interface. Periodically pulses the
//   ADC start, waits out the conversion via the ADC done flag, and captures each sample.
//   Emits every raw sample plus a boxcar average of 2**LOG2_AVG samples.
//   Sits between the ADC interface and the application logic. Flags stuck-converter
//   (timeout) and sample-rate overrun faults.
// PARAMETERS
//   DIV           100  clk cycles between conversion-start ticks; legal range >= 24
//   LOG2_AVG      3    log2 of the number of samples per average; legal range 0..6
//   BUSY_TIMEOUT  4    cycles after adc_start within which adc_done must go low
// PORTS
//   clk        in   1   system clock; all logic on posedge; ADC interface runs on negedge of same clk
//   rst        in   1   synchronous reset, active-high
//   en         in   1   1 = run periodic sampling; 0 = stop and clear the averager
//   adc_start  out  1   one-cycle pulse requesting a conversion
//   adc_done   in   1   ADC idle/complete flag; high when idle, low during conversion
//   adc_dout   in   10  ADC result; stable while adc_done is high
//   raw        out  10  last captured sample
//   raw_valid  out  1   one-cycle pulse: raw updated this cycle
//   avg        out  10  last completed average
//   avg_valid  out  1   one-cycle pulse: avg updated this cycle
//   timeout    out  1   sticky flag: adc_done failed to drop after adc_start
//   overrun    out  1   sticky flag: period tick arrived while a conversion was in flight
//   fault_clr  in   1   clears timeout and overrun (set wins if coincident)
// BEHAVIOUR
//   Reset: adc_start, raw, raw_valid, avg, avg_valid, timeout, overrun = 0.
//     Also: FSM=IDLE, tick counter=0, accumulator=0, sample count=0.
//   Tick counter: counts 0..DIV-1 while en=1, wrapping; tick at DIV-1. Held at 0 while en=0.
//   FSM states and transitions:
//     IDLE:  tick & adc_done=1 -> START. Tick & adc_done=0 -> overrun<=1; stay in IDLE.
//     START: adc_start=1 for exactly this cycle -> BUSY.
//     BUSY:  adc_done=0 -> CONV. If adc_done stays 1 for BUSY_TIMEOUT cycles,
//            timeout<=1 -> IDLE; no sample is produced.
//     CONV:  adc_done=1 -> CAPT. A tick seen in START, BUSY or CONV sets overrun<=1;
//            that tick is dropped, never queued.
//     CAPT:  raw<=adc_dout, raw_valid=1 in the next cycle; accumulate; -> IDLE.
//   Latency: raw_valid is high exactly 1 cycle after the first posedge sampling adc_done=1 in CONV.
//   Averager: accumulator is 10+LOG2_AVG bits, unsigned; it cannot overflow.
//     On the Nth sample (N=2**LOG2_AVG): avg <= (acc + sample) >> LOG2_AVG, truncated.
//     avg_valid pulses in the same cycle as that sample's raw_valid.
//     The accumulator and count then restart at 0. LOG2_AVG=0 gives avg=raw.
//   en deassert: tick generation stops, accumulator and count are cleared.
//     A conversion already in flight runs to completion, but its sample is discarded
//     (no raw_valid, no accumulation). The FSM then idles.
//   Reset mid-operation: all of the above return to reset values on the next cycle.
//     adc_start is never truncated into a partial pulse. The ADC may finish a conversion
//     unobserved, and it is ignored.
//   raw and avg hold their values between valid pulses.
// TESTING
//   1. rst=1 for 3 cycles with en=1 -> all outputs 0, no adc_start; after release the
//      first adc_start comes at cycle DIV.
//   2. DIV=32, LOG2_AVG=2, ADC model returns 100,200,300,400
//      -> 4 raw_valid pulses with those values; avg=250 with avg_valid on the 4th.
//   3. LOG2_AVG=2, samples 1,1,1,2 -> avg=1 (truncation).
//      Samples 1023 x4 -> avg=1023 (no overflow).
//   4. adc_done tied high -> timeout=1 BUSY_TIMEOUT cycles after adc_start, no raw_valid.
//      fault_clr pulse -> timeout=0.
//   5. ADC model stretches a conversion past DIV -> overrun=1, that tick skipped,
//      next conversion starts on the following tick.
//   6. en dropped during CONV -> no raw_valid for that conversion. After re-enable,
//      the first avg uses 4 fresh samples only.
//      rst during CONV -> adc_start=0 and FSM in IDLE next cycle.

Source files
------------

// File: rtl/adc_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_sampler
// Purpose  : Periodic ADC conversion sequencer with raw capture, boxcar
//            averaging and sticky timeout/overrun fault flags.
// Revision : 1.0  initial release
// ============================================================================
module adc_sampler #(
    parameter int DIV          = 100,
    parameter int LOG2_AVG     = 3,
    parameter int BUSY_TIMEOUT = 4   // must be >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       adc_start,
    input  logic       adc_done,
    input  logic [9:0] adc_dout,
    output logic [9:0] raw,
    output logic       raw_valid,
    output logic [9:0] avg,
    output logic       avg_valid,
    output logic       timeout,
    output logic       overrun,
    input  logic       fault_clr
);

    localparam int CW    = $clog2(DIV);
    localparam int BW    = $clog2(BUSY_TIMEOUT + 1);
    localparam int AW    = 10 + LOG2_AVG;
    localparam int SW    = LOG2_AVG + 1;
    localparam int N_AVG = 1 << LOG2_AVG;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_CONV  = 3'd3,
        S_CAPT  = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic [BW-1:0]   busy_cnt;
    logic            keep;
    logic            set_overrun, set_timeout, capture, accept;
    logic [AW-1:0]   acc, sum;
    logic [SW-1:0]   sample_cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            tick_cnt <= '0;
        end else if (tick_cnt == CW'(DIV - 1)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = en && (tick_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        adc_start   = 1'b0;
        set_overrun = 1'b0;
        set_timeout = 1'b0;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    if (adc_done) begin
                        state_nx = S_START;
                    end else begin
                        set_overrun = 1'b1;
                    end
                end
            end
            S_START: begin
                adc_start   = 1'b1;
                set_overrun = tick;
                state_nx    = S_BUSY;
            end
            S_BUSY: begin
                set_overrun = tick;
                if (!adc_done) begin
                    state_nx = S_CONV;
                end else if (busy_cnt == BW'(BUSY_TIMEOUT - 1)) begin
                    // The START cycle counts toward the window, hence the -1.
                    set_timeout = 1'b1;
                    state_nx    = S_IDLE;
                end
            end
            S_CONV: begin
                set_overrun = tick;
                if (adc_done) begin
                    state_nx = S_CAPT;
                end
            end
            S_CAPT: begin
                capture  = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            busy_cnt <= '0;
        end else if (state == S_START || state == S_BUSY) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    // Any low cycle of en during a conversion disqualifies its sample.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            keep <= 1'b0;
        end else if (state == S_START) begin
            keep <= 1'b1;
        end
    end

    assign accept = capture && keep && en;
    assign sum    = acc + AW'(adc_dout);

    always_ff @(posedge clk) begin
        if (rst) begin
            raw        <= '0;
            raw_valid  <= 1'b0;
            avg        <= '0;
            avg_valid  <= 1'b0;
            acc        <= '0;
            sample_cnt <= '0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            raw_valid <= 1'b0;
            avg_valid <= 1'b0;
            timeout   <= set_timeout | (timeout & ~fault_clr);
            overrun   <= set_overrun | (overrun & ~fault_clr);
            if (!en) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else if (accept) begin
                raw       <= adc_dout;
                raw_valid <= 1'b1;
                if (sample_cnt == SW'(N_AVG - 1)) begin
                    avg        <= sum[LOG2_AVG +: 10];
                    avg_valid  <= 1'b1;
                    acc        <= '0;
                    sample_cnt <= '0;
                end else begin
                    acc        <= sum;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adc_sampler
// Purpose  : Directed bench for adc_sampler with an ADC model and a
//            transaction-level expectation model of samples and averages.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_sampler;

    localparam int DIV = 32;
    localparam int L2  = 2;
    localparam int BT  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       fault_clr = 1'b0;
    logic       adc_done = 1'b1;
    logic [9:0] adc_dout = '0;
    logic       adc_start, raw_valid, avg_valid, timeout, overrun;
    logic [9:0] raw, avg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_sampler #(.DIV(DIV), .LOG2_AVG(L2), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .en(en), .adc_start(adc_start), .adc_done(adc_done),
        .adc_dout(adc_dout), .raw(raw), .raw_valid(raw_valid), .avg(avg),
        .avg_valid(avg_valid), .timeout(timeout), .overrun(overrun), .fault_clr(fault_clr)
    );

    task automatic check(input string nm, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, expv);
        end
    endtask

    task automatic no_event(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no event expected event", nm);
    endtask

    // ADC model: runs on negedge, drops done on start, returns a queued value.
    typedef struct {
        int due;
        int val;
        bit has_avg;
        int avgv;
    } exp_t;

    bit   tied     = 1'b0;
    int   conv_len = 5;
    int   vals[$];
    exp_t expq[$];
    bit   busy  = 1'b0;
    bit   clean = 1'b0;
    int   remain = 0;
    int   m_sum = 0;
    int   m_n   = 0;

    always @(negedge clk) begin : adc_model
        exp_t ne;
        int   v;
        if (rst || !en) begin
            m_sum = 0;
            m_n   = 0;
        end
        if (busy) begin
            clean  = clean && en && !rst;
            remain = remain - 1;
            if (remain == 0) begin
                v        = (vals.size() > 0) ? vals.pop_front() : 0;
                adc_dout = 10'(v);
                adc_done = 1'b1;
                busy     = 1'b0;
                if (clean) begin
                    m_sum      = m_sum + v;
                    m_n        = m_n + 1;
                    ne.due     = cyc + 2;
                    ne.val     = v;
                    ne.has_avg = (m_n == (1 << L2));
                    ne.avgv    = m_sum / (1 << L2);
                    if (ne.has_avg) begin
                        m_sum = 0;
                        m_n   = 0;
                    end
                    expq.push_back(ne);
                end
            end
        end else if (adc_start && !tied) begin
            busy     = 1'b1;
            adc_done = 1'b0;
            remain   = conv_len;
            clean    = en && !rst;
        end
    end

    logic [9:0] e_raw = '0;
    logic [9:0] e_avg = '0;
    bit         prev_start = 1'b0;

    always @(negedge clk) begin : compare
        exp_t e;
        bit   ev;
        e  = '{default: 0};
        ev = 1'b0;
        if (rst) begin
            expq.delete();
            e_raw      = '0;
            e_avg      = '0;
            prev_start = 1'b0;
        end else begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                ev    = 1'b1;
                e     = expq.pop_front();
                e_raw = 10'(e.val);
                if (e.has_avg) e_avg = 10'(e.avgv);
            end
            check("raw_valid", int'(raw_valid), int'(ev));
            check("raw", int'(raw), int'(e_raw));
            check("avg_valid", int'(avg_valid), int'(ev && e.has_avg));
            check("avg", int'(avg), int'(e_avg));
            check("start_one_cycle", int'(prev_start && adc_start), 0);
            prev_start = adc_start;
        end
    end

    task automatic wait_start(input string nm, output int c);
        c = -1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (adc_start) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) no_event(nm);
    endtask

    task automatic wait_raw(input string nm, input int expv);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (raw_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) check(nm, int'(raw), expv);
        else      no_event(nm);
    endtask

    task automatic wait_avg(input string nm, input int expv);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (avg_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) check(nm, int'(avg), expv);
        else      no_event(nm);
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int k, s1, s2;
        rst = 1'b1;
        en  = 1'b1;
        vals = '{100, 200, 300, 400};
        repeat (3) begin
            step();
            check("reset_outputs",
                  int'({adc_start, raw_valid, avg_valid, timeout, overrun, raw, avg}), 0);
        end
        rst = 1'b0;

        // First start request lands DIV cycles after reset release.
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            k++;
            if (adc_start) break;
        end
        check("first_start_cycle", k, DIV);

        wait_raw("raw_100", 100);
        wait_raw("raw_200", 200);
        wait_raw("raw_300", 300);
        wait_raw("raw_400", 400);
        check("avg4_valid", int'(avg_valid), 1);
        check("avg4_value", int'(avg), 250);

        vals = '{1, 1, 1, 2};
        wait_avg("avg_trunc", 1);
        vals = '{1023, 1023, 1023, 1023};
        wait_avg("avg_max", 1023);

        // Stuck converter: done never drops.
        tied = 1'b1;
        wait_start("timeout_start", s1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            k++;
            if (timeout) break;
        end
        check("timeout_latency", k, BT);
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("timeout_cleared", int'(timeout), 0);
        tied = 1'b0;

        // Over-long conversion swallows one tick.
        conv_len = DIV + 10;
        wait_start("ovr_start1", s1);
        repeat (3) @(posedge clk);
        conv_len = 5;
        wait_start("ovr_start2", s2);
        check("overrun_gap", s2 - s1, 2 * DIV);
        check("overrun_set", int'(overrun), 1);
        check("timeout_still_clear", int'(timeout), 0);
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("overrun_cleared", int'(overrun), 0);

        // en dropped mid-conversion: partial average and that sample vanish.
        en = 1'b0;
        repeat (60) @(posedge clk);
        vals = '{10, 20, 999, 4, 8, 12, 16};
        step();
        en = 1'b1;
        wait_raw("pre_drop_10", 10);
        wait_raw("pre_drop_20", 20);
        wait_start("drop_start", s1);
        repeat (3) @(posedge clk);
        #2 en = 1'b0;
        repeat (20) @(posedge clk);
        #2 en = 1'b1;
        wait_raw("fresh_4", 4);
        wait_raw("fresh_8", 8);
        wait_raw("fresh_12", 12);
        wait_raw("fresh_16", 16);
        check("fresh_avg_valid", int'(avg_valid), 1);
        check("fresh_avg", int'(avg), 10);

        // Reset in the middle of a conversion.
        vals = '{555};
        wait_start("rst_start", s1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_conv_start", int'(adc_start), 0);
        check("rst_conv_raw", int'(raw), 0);
        check("rst_conv_avg", int'(avg), 0);
        check("rst_conv_flags", int'({raw_valid, avg_valid, timeout, overrun}), 0);
        step();
        rst = 1'b0;
        repeat (DIV + 30) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
